// File: rtl/fmul.sv
// Single-precision (binary32) multiplier, one registered stage.
// Round-to-nearest-even, full subnormal input/output support, IEEE specials.
// Optional exception flags output enabled by defining FMUL_EXC_FLAGS_EN.
module fmul (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [31:0] out,
  output logic        out_valid
`ifdef FMUL_EXC_FLAGS_EN
  ,
  output logic [4:0]  flags
`endif
);

  logic [7:0]  w_ea, w_eb;
  logic [22:0] w_fa, w_fb;
  logic        w_a_nan, w_b_nan, w_a_inf, w_b_inf, w_a_zero, w_b_zero;
  logic        w_sign;
  logic [23:0] w_ma, w_mb;
  logic [7:0]  w_exa, w_exb;
  logic [47:0] w_prod, w_norm;
  logic [5:0]  w_lz;
  logic signed [9:0] w_exp, w_exp_r;
  logic        w_tiny;
  logic [9:0]  w_sh;
  logic [47:0] w_sig_ext, w_lost;
  logic        w_sh_sticky;
  logic [23:0] w_sig;
  logic        w_g, w_r, w_st, w_rup, w_ovf;
  logic [24:0] w_sum;
  logic [22:0] w_frac_r;
  logic [31:0] w_res;

  assign w_ea = a[30:23];
  assign w_eb = b[30:23];
  assign w_fa = a[22:0];
  assign w_fb = b[22:0];

  assign w_a_nan  = (&w_ea) & (|w_fa);
  assign w_b_nan  = (&w_eb) & (|w_fb);
  assign w_a_inf  = (&w_ea) & ~(|w_fa);
  assign w_b_inf  = (&w_eb) & ~(|w_fb);
  assign w_a_zero = ~(|w_ea) & ~(|w_fa);
  assign w_b_zero = ~(|w_eb) & ~(|w_fb);
  assign w_sign   = a[31] ^ b[31];

  // Subnormals carry no hidden one and use exponent 1.
  assign w_ma  = {|w_ea, w_fa};
  assign w_mb  = {|w_eb, w_fb};
  assign w_exa = (|w_ea) ? w_ea : 8'd1;
  assign w_exb = (|w_eb) ? w_eb : 8'd1;

  assign w_prod = w_ma * w_mb;

  // Leading-zero count of the raw product (highest set bit wins).
  always_comb begin
    w_lz = 6'd0;
    for (int i = 0; i < 48; i++) begin
      if (w_prod[i]) w_lz = 6'(47 - i);
    end
  end

  // Leading one moved to bit 47; exponent tracks it, so a product >= 2
  // (lz = 0) gets +1 and subnormal-driven shifts get decremented.
  assign w_norm = w_prod << w_lz;
  assign w_exp  = $signed({2'b00, w_exa}) + $signed({2'b00, w_exb})
                - 10'sd127 + 10'sd1 - $signed({4'b0000, w_lz});
  assign w_tiny = (w_exp <= 10'sd0);
  assign w_sh   = 10'd1 - w_exp;

  // Denormalize tiny results; very large shifts leave only sticky.
  always_comb begin
    w_sig_ext   = w_norm;
    w_lost      = 48'd0;
    w_sh_sticky = 1'b0;
    if (w_tiny) begin
      if (w_sh >= 10'd26) begin
        w_sig_ext   = 48'd0;
        w_sh_sticky = 1'b1;
      end else begin
        {w_sig_ext, w_lost} = {w_norm, 48'd0} >> w_sh[4:0];
        w_sh_sticky         = |w_lost;
      end
    end
  end

  assign w_sig = w_sig_ext[47:24];
  assign w_g   = w_sig_ext[23];
  assign w_r   = w_sig_ext[22];
  assign w_st  = (|w_sig_ext[21:0]) | w_sh_sticky;
  assign w_rup = w_g & (w_r | w_st | w_sig[0]);
  assign w_sum = {1'b0, w_sig} + {24'd0, w_rup};

  // Rounding carry renormalizes; a subnormal reaching bit 23 becomes normal.
  assign w_exp_r  = w_tiny ? (w_sum[23] ? 10'sd1 : 10'sd0)
                           : (w_exp + $signed({9'd0, w_sum[24]}));
  assign w_frac_r = w_sum[24] ? w_sum[23:1] : w_sum[22:0];
  assign w_ovf    = ~w_tiny & (w_exp_r >= 10'sd255);

  // Final result selection with special values taking priority.
  always_comb begin
    w_res = {w_sign, w_exp_r[7:0], w_frac_r};
    if (w_a_nan | w_b_nan)
      w_res = 32'h7FC00000;
    else if ((w_a_inf & w_b_zero) | (w_a_zero & w_b_inf))
      w_res = 32'h7FC00000;
    else if (w_a_inf | w_b_inf)
      w_res = {w_sign, 8'hFF, 23'd0};
    else if (w_a_zero | w_b_zero)
      w_res = {w_sign, 31'd0};
    else if (w_ovf)
      w_res = {w_sign, 8'hFF, 23'd0};
  end

  // Output register: loads on accepted operation, holds otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out       <= 32'h00000000;
      out_valid <= 1'b0;
    end else begin
      out_valid <= in_valid;
      if (in_valid) out <= w_res;
    end
  end

`ifdef FMUL_EXC_FLAGS_EN
  logic       w_invalid, w_special, w_inexact;
  logic [4:0] w_flags;

  assign w_invalid = w_a_nan | w_b_nan | (w_a_inf & w_b_zero) | (w_a_zero & w_b_inf);
  assign w_special = w_a_nan | w_b_nan | w_a_inf | w_b_inf | w_a_zero | w_b_zero;
  assign w_inexact = w_g | w_r | w_st | w_ovf;

  // Flags only describe finite arithmetic; specials raise invalid at most.
  always_comb begin
    w_flags = {w_invalid, 4'b0000};
    if (!w_special)
      w_flags = {1'b0, 1'b0, w_ovf, w_tiny & w_inexact, w_inexact};
  end

  // Flags register travels with out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) flags <= 5'd0;
    else if (in_valid) flags <= w_flags;
  end
`endif

endmodule

// File: tb/tb_fmul.sv
// Self-checking bench for fmul: exact-integer reference model plus
// directed vectors with hand-computed results and a mixed sweep.
module tb_fmul;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic [31:0] out;
  logic        out_valid;
`ifdef FMUL_EXC_FLAGS_EN
  logic [4:0]  flags;
  logic [4:0]  m_flags;
`endif

  int n_checks = 0;
  int n_fail = 0;

  logic        m_valid;
  logic [31:0] m_out;

  always #5 clk = ~clk;

  fmul dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .a(a),
    .b(b),
    .out(out),
    .out_valid(out_valid)
`ifdef FMUL_EXC_FLAGS_EN
    ,
    .flags(flags)
`endif
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s actual=%h required=%h at %0t", nm, act, req, $time);
    end
  endtask

  // Exact product P*2^E, rounded RNE onto the binary32 grid (quantum 2^q).
  // Returns {flags, result}.
  function automatic logic [36:0] fp_model(input logic [31:0] x, input logic [31:0] y);
    logic s, xn, yn, xi, yi, xz, yz, inx, ovf, tiny;
    longint P, N, rem, half;
    int ex, ey, E, msb, q, k;
    logic [31:0] r;
    s  = x[31] ^ y[31];
    xn = (x[30:23] == 8'hFF) && (x[22:0] != 0);
    yn = (y[30:23] == 8'hFF) && (y[22:0] != 0);
    xi = (x[30:23] == 8'hFF) && (x[22:0] == 0);
    yi = (y[30:23] == 8'hFF) && (y[22:0] == 0);
    xz = (x[30:0] == 0);
    yz = (y[30:0] == 0);
    if (xn || yn) return {5'b10000, 32'h7FC00000};
    if ((xi && yz) || (xz && yi)) return {5'b10000, 32'h7FC00000};
    if (xi || yi) return {5'b00000, s, 8'hFF, 23'd0};
    if (xz || yz) return {5'b00000, s, 31'd0};
    P  = longint'({x[30:23] != 0, x[22:0]}) * longint'({y[30:23] != 0, y[22:0]});
    ex = (x[30:23] == 0) ? 1 : int'(x[30:23]);
    ey = (y[30:23] == 0) ? 1 : int'(y[30:23]);
    E  = ex + ey - 300;
    msb = 0;
    for (int i = 0; i < 48; i++) if (P[i]) msb = i;
    tiny = (msb + E) < -126;
    q = msb + E - 23;
    if (q < -149) q = -149;
    k = q - E;
    inx = 1'b0;
    if (k <= 0) N = P << (-k);
    else if (k >= 60) begin
      N = 0;
      inx = 1'b1;
    end else begin
      N    = P >> k;
      rem  = P & ((64'sd1 << k) - 1);
      half = 64'sd1 << (k - 1);
      inx  = (rem != 0);
      if (rem > half || (rem == half && N[0])) N = N + 1;
    end
    if (N == (64'sd1 << 24)) begin
      N = N >> 1;
      q++;
    end
    ovf = 1'b0;
    if (N < (64'sd1 << 23)) r = {s, 8'h00, N[22:0]};
    else if (q + 150 >= 255) begin
      r = {s, 8'hFF, 23'd0};
      ovf = 1'b1;
    end else r = {s, 8'(q + 150), N[22:0]};
    inx = inx | ovf;
    return {1'b0, 1'b0, ovf, tiny & inx, inx, r};
  endfunction

  // Reference output register behaviour.
  always @(posedge clk or negedge rst_n) begin
    logic [36:0] m;
    if (!rst_n) begin
      m_valid <= 1'b0;
      m_out   <= 32'd0;
`ifdef FMUL_EXC_FLAGS_EN
      m_flags <= 5'd0;
`endif
    end else begin
      m = fp_model(a, b);
      m_valid <= in_valid;
      if (in_valid) begin
        m_out <= m[31:0];
`ifdef FMUL_EXC_FLAGS_EN
        m_flags <= m[36:32];
`endif
      end
    end
  end

  // Every cycle out of reset: DUT must agree with the model.
  always @(negedge clk) begin
    if (rst_n) begin
      chk("cmp_valid", {31'd0, out_valid}, {31'd0, m_valid});
      chk("cmp_out", out, m_out);
`ifdef FMUL_EXC_FLAGS_EN
      if (m_valid) chk("cmp_flags", {27'd0, flags}, {27'd0, m_flags});
`endif
      if (m_valid) $display("txn out=%h", m_out);
    end
  end

  // Directed op with hand-computed result; also pins the model.
  task automatic lit(input string nm, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] e);
    logic [36:0] m;
    m = fp_model(x, y);
    chk({nm, "_model"}, m[31:0], e);
    @(negedge clk);
    in_valid = 1'b1;
    a = x;
    b = y;
    @(posedge clk);
    #1;
    chk({nm, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk(nm, out, e);
  endtask

  function automatic logic [31:0] rnd_fp();
    int c;
    logic [31:0] v;
    c = $urandom_range(0, 9);
    v = $urandom;
    case (c)
      0: v[30:23] = 8'h00;
      1: begin
        case ($urandom_range(0, 3))
          0: v[30:0] = 31'd0;
          1: v[30:0] = {8'hFF, 23'd0};
          2: v[30:0] = {8'hFF, 23'h400001};
          default: v[30:0] = 31'h7F7FFFFF;
        endcase
      end
      2, 3: ;
      default: v[30:23] = 8'($urandom_range(40, 215));
    endcase
    return v;
  endfunction

  initial begin
    repeat (2) @(posedge clk);
    #1;
    chk("reset_out", out, 32'd0);
    chk("reset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    lit("norm_2x3",   32'h40000000, 32'h40400000, 32'h40C00000);
    lit("norm_m1m1",  32'hBF800000, 32'hBF800000, 32'h3F800000);
    lit("norm_m1p1",  32'hBF800000, 32'h3F800000, 32'hBF800000);
    lit("zero_neg",   32'h80000000, 32'h40000000, 32'h80000000);
    lit("inf_neg",    32'hFF800000, 32'h40000000, 32'hFF800000);
    lit("inf_pos",    32'h40000000, 32'h7F800000, 32'h7F800000);
    lit("nan_in",     32'h7FC00000, 32'h40000000, 32'h7FC00000);
    lit("inf_x_0",    32'h7F800000, 32'h00000000, 32'h7FC00000);
    lit("0_x_ninf",   32'h00000000, 32'hFF800000, 32'h7FC00000);
    lit("sub_min",    32'h00000001, 32'h3F800000, 32'h00000001);
    lit("sub_half",   32'h00800000, 32'h3F000000, 32'h00400000);
    lit("sub_to_nrm", 32'h007FFFFF, 32'h3F800001, 32'h00800000);
    lit("uflow_zero", 32'h80000001, 32'h00000001, 32'h80000000);
    lit("rnd_sticky", 32'h3F800001, 32'h3F800001, 32'h3F800002);
    lit("tie_up",     32'h3FC00000, 32'h3F800001, 32'h3FC00002);
    lit("tie_even",   32'h3FC00000, 32'h3F800003, 32'h3FC00004);
    lit("overflow",   32'h7F7FFFFF, 32'h40000000, 32'h7F800000);

    // One idle cycle: valid drops, value holds.
    @(negedge clk);
    in_valid = 1'b0;
    a = 32'h40400000;
    b = 32'h40400000;
    @(posedge clk);
    #1;
    chk("idle_valid", {31'd0, out_valid}, 32'd0);
    chk("idle_hold", out, 32'h7F800000);

    // Asynchronous reset between edges with a live result.
    lit("pre_reset", 32'h40000000, 32'h40000000, 32'h40800000);
    #2;
    rst_n = 1'b0;
    #1;
    chk("areset_out", out, 32'd0);
    chk("areset_valid", {31'd0, out_valid}, 32'd0);
    @(negedge clk);
    in_valid = 1'b0;
    rst_n = 1'b1;

    // Back-to-back results in order after reset.
    lit("b2b_first",  32'h40400000, 32'h40400000, 32'h41100000);
    lit("b2b_second", 32'hC0000000, 32'h40800000, 32'hC1000000);

    // Mixed sweep, checked cycle by cycle against the model.
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      in_valid = ($urandom_range(0, 7) != 0);
      a = rnd_fp();
      b = rnd_fp();
    end
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
